// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding fetch into a small FIFO feeding decode.
// Redirects flush the FIFO and discard any fetch still in flight.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [31:0] instr_buf_q [BUF_DEPTH];
  logic [31:0] pc_buf_q    [BUF_DEPTH];

  logic             pop;
  logic             resp;
  logic             push;
  logic             issue;
  logic [CNT_W-1:0] count_after;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & ~stall & ~redirect;
  assign resp        = imem_valid & outstanding_q;
  assign push        = resp & ~drop_q & ~redirect;
  assign count_after = count_q - CNT_W'(pop) + CNT_W'(push);

  // A new request may go out in the same cycle the previous one returns, but
  // only if the FIFO will still have a free slot for its eventual response.
  assign issue     = rst_n & ~redirect & (~outstanding_q | resp) & (count_after < DEPTH_C);
  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    armed_d       = armed_q | issue;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      outstanding_d = 1'b1;
    end else if (resp) begin
      outstanding_d = 1'b0;
    end
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = outstanding_q & ~imem_valid;
    end else begin
      if (drop_q && resp) drop_d = 1'b0;
      count_d = count_after;
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      armed_q       <= 1'b0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      armed_q       <= armed_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  // A pushed response always belongs to the request issued just before
  // fetch_pc advanced, so its PC is fetch_pc - 4.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_buf_q[tail_q] <= imem_rdata;
      pc_buf_q[tail_q]    <= fetch_pc_q - 32'd4;
    end
  end

  assign instr    = instr_valid ? instr_buf_q[head_q] : NOP_INSTR;
  assign pc_out   = instr_valid ? pc_buf_q[head_q] : 32'h0;
  assign pc_plus4 = pc_out + 32'd4;

  // A stray response left over from before reset is tolerated until the first issue.
  assert property (@(posedge clk) disable iff (!rst_n)
    imem_valid |-> (outstanding_q || !armed_q))
    else $error("if_stage: imem_valid with no request outstanding");

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: latency-randomised memory responder plus a queue-based
// model of the delivered instruction stream, tagged by redirect/reset epoch.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;

  if_stage #(
    .RESET_PC (RESET_PC),
    .BUF_DEPTH(BUF_DEPTH),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .instr      (instr),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  req_t        mq[$];
  ent_t        fifo[$];
  int          total, bad, cyc, epoch, deliveries, lat_min, lat_max, n;
  logic [31:0] exp_req;
  bit          stray, resp_from_q;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic mem_drive();
    resp_from_q = 1'b0;
    imem_valid  = 1'b0;
    imem_rdata  = 32'h0;
    if (stray) begin
      imem_valid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      stray      = 1'b0;
    end else if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_valid  = 1'b1;
      imem_rdata  = memf(mq[0].addr);
      resp_from_q = 1'b1;
    end
  endtask

  task automatic check_update();
    req_t r;
    ent_t e;
    bit   accept;
    bit   pop;
    chk("instr_valid", 32'(fifo.size() > 0), 32'(instr_valid));
    if (fifo.size() > 0) begin
      chk("pc_out", pc_out, fifo[0].pc);
      chk("instr", instr, fifo[0].ins);
      chk("pc_plus4", pc_plus4, fifo[0].pc + 32'd4);
    end else begin
      chk("instr_nop", instr, NOP_INSTR);
    end
    if (redirect) chk("req_in_redirect", 32'(imem_req), 0);
    if (imem_req) begin
      chk("req_addr", imem_addr, exp_req);
      chk("single_outstanding", 32'(mq.size() - int'(resp_from_q)), 0);
    end
    accept = 1'b0;
    if (resp_from_q) begin
      r = mq.pop_front();
      accept = !redirect && (r.epoch == epoch);
    end
    pop = (fifo.size() > 0) && !stall && !redirect;
    if (pop) begin
      void'(fifo.pop_front());
      deliveries++;
    end
    if (redirect) begin
      fifo.delete();
      epoch++;
      exp_req = redirect_pc;
    end
    if (accept) begin
      e.pc  = r.addr;
      e.ins = memf(r.addr);
      fifo.push_back(e);
      chk("fifo_bound", 32'(fifo.size() <= BUF_DEPTH), 1);
    end
    if (imem_req) begin
      r.addr  = imem_addr;
      r.epoch = epoch;
      r.due   = cyc + int'($urandom_range(lat_max, lat_min));
      mq.push_back(r);
      exp_req = exp_req + 32'd4;
    end
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
    check_update();
    @(posedge clk);
    #1;
    cyc++;
    mem_drive();
  endtask

  task automatic reset_chk();
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
  endtask

  task automatic apply_reset(input bit late);
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_valid  = 1'b0;
    resp_from_q = 1'b0;
    #1;
    reset_chk();
    fifo.delete();
    mq.delete();
    epoch++;
    exp_req = RESET_PC;
    repeat (2) begin
      @(negedge clk);
      reset_chk();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    stray = late;
    mem_drive();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0; stray = 1'b0; resp_from_q = 1'b0;
    total = 0; bad = 0; cyc = 0; epoch = 0; deliveries = 0;
    lat_min = 1; lat_max = 1; exp_req = RESET_PC;
    #2;
    apply_reset(1'b0);

    // cold start with 1-cycle memory: head valid two cycles after release
    repeat (2) step(1'b0, 1'b0, 32'h0);
    chk("first_valid_cycle2", 32'(instr_valid), 1);
    chk("first_pc", pc_out, RESET_PC);

    // stall holds the head while the buffer fills
    repeat (6) step(1'b1, 1'b0, 32'h0);
    chk("stall_hold_pc", pc_out, RESET_PC);
    repeat (8) step(1'b0, 1'b0, 32'h0);

    // redirect while a 3-cycle fetch is in flight
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!(mq.size() > 0 && !imem_valid) && n < 20) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("inflight_found", 32'(n < 20), 1);
    step(1'b0, 1'b1, 32'h100);
    repeat (12) step(1'b0, 1'b0, 32'h0);

    // redirect in the same cycle as a response, with stall held
    lat_min = 1; lat_max = 2;
    n = 0;
    while (!resp_from_q && n < 20) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("valid_found", 32'(n < 20), 1);
    step(1'b1, 1'b1, 32'h200);
    chk("flush_valid", 32'(instr_valid), 0);
    chk("flush_nop", instr, NOP_INSTR);
    repeat (10) step(1'b0, 1'b0, 32'h0);

    // PC wrap across the top of the address space
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (14) step(1'b0, 1'b0, 32'h0);

    // reset with a fetch outstanding, stray response right after release
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!(mq.size() > 0 && !imem_valid) && n < 20) begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("inflight_before_reset", 32'(n < 20), 1);
    apply_reset(1'b1);
    repeat (10) step(1'b0, 1'b0, 32'h0);

    // randomised traffic
    lat_min = 1; lat_max = 3;
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [31:0] t;
      rd = ($urandom_range(99) < 5);
      if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
      else                        t = 32'($urandom_range(16383)) << 2;
      step($urandom_range(99) < 30, rd, t);
    end
    chk("progress", 32'(deliveries > 300), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
